psum_accumulator: RTL and testbench

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

---
 rtl/psum_accumulator_pkg.sv | 19 +
 rtl/psum_counter.sv | 28 ++
 rtl/psum_accumulator.sv | 88 ++++++++
 tb/tb_psum_accumulator.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/psum_accumulator_pkg.sv
// psum_accumulator_pkg: FSM encodings and counter sizing shared by the
// partial-sum accumulator and its term counter.
package psum_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int DEF_NUM_PSUM = 4;
    localparam int CNT_W        = $clog2(DEF_NUM_PSUM + 1);

    // Count width able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/psum_counter.sv
// psum_counter: loadable up-counter with clear (highest priority), load and
// enable; o_tc flags that the count equals TC.
module psum_counter #(
    parameter int W  = 3,
    parameter int TC = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = i_clear ? '0 : i_load ? i_load_val : i_en ? cnt_q + 1'b1 : cnt_q;
        o_tc  = (cnt_q == W'(TC));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: sums NUM_PSUM unsigned upstream terms into one
// ACC_WIDTH-bit result, held under valid/ready with a sticky wrap flag.
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int IN_WIDTH  = 5,
    parameter int ACC_WIDTH = 8,
    parameter int NUM_PSUM  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic                 i_clear,
    input  logic                 i_valid,
    input  logic [IN_WIDTH-1:0]  i_data_bus,
    output logic                 o_ready,
    output logic                 o_valid,
    output logic [ACC_WIDTH-1:0] o_data_bus,
    output logic                 o_overflow,
    input  logic                 i_ready
);

    localparam int CW = cnt_width(NUM_PSUM);

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d, res_q, res_d, acc_nx, sum;
    logic                 ovf_q, ovf_d, ovf_nx, carry;
    logic                 accept, pop, last;

    // o_tc is high while the counter sits one short of a full group, so the
    // term being accepted now is the last one (count 0 covers NUM_PSUM=1).
    psum_counter #(
        .W  (CW),
        .TC (NUM_PSUM - 1)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (i_clear | pop),
        .i_load     (accept & (state_q == IDLE)),
        .i_load_val (CW'(1)),
        .i_en       (accept & (state_q == ACC)),
        .o_tc       (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_clear)     state_d = IDLE;
        else if (pop)    state_d = IDLE;
        else if (accept) state_d = last ? HOLD : ACC;
    end

    always_comb begin
        o_ready    = rst_n & i_en & (state_q != HOLD);
        o_valid    = (state_q == HOLD);
        o_overflow = (state_q == HOLD) & ovf_q;
        o_data_bus = res_q;
    end

    assign accept = i_valid & o_ready;
    assign pop    = i_en & i_ready & (state_q == HOLD);

    always_comb begin
        {carry, sum} = {1'b0, acc_q} + (ACC_WIDTH + 1)'(i_data_bus);
        acc_nx = (state_q == IDLE) ? ACC_WIDTH'(i_data_bus) : sum;
        ovf_nx = (state_q != IDLE) & (ovf_q | carry);
        acc_d  = i_clear ? '0 : accept ? acc_nx : acc_q;
        ovf_d  = i_clear ? 1'b0 : accept ? ovf_nx : ovf_q;
        res_d  = (accept & last & ~i_clear) ? acc_nx : res_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            res_q <= '0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            res_q <= res_d;
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed and random stimulus on three configurations,
// checked against a group-sum reference model.
module tb_psum_accumulator;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b1, clr = 1'b0, vld = 1'b0, rdy = 1'b0;
    logic [4:0] din = '0;
    logic       rdy_o [3];
    logic       vld_o [3];
    logic       ovf_o [3];
    logic [7:0] dout  [3];
    logic [5:0] d1;
    int         checks = 0, failures = 0;
    bit         chk_on = 1'b0;

    int     aw [3] = '{8, 6, 8};
    int     np [3] = '{4, 4, 1};
    int     m_cnt  [3];
    longint m_sum  [3];
    bit     m_hold [3];
    int     m_res  [3];
    bit     m_ovf  [3];

    always #5 clk = ~clk;

    psum_accumulator #(.IN_WIDTH(5), .ACC_WIDTH(8), .NUM_PSUM(4)) u0 (
        .clk(clk), .rst_n(rst_n), .i_en(en), .i_clear(clr), .i_valid(vld), .i_data_bus(din),
        .o_ready(rdy_o[0]), .o_valid(vld_o[0]), .o_data_bus(dout[0]), .o_overflow(ovf_o[0]),
        .i_ready(rdy));
    psum_accumulator #(.IN_WIDTH(5), .ACC_WIDTH(6), .NUM_PSUM(4)) u1 (
        .clk(clk), .rst_n(rst_n), .i_en(en), .i_clear(clr), .i_valid(vld), .i_data_bus(din),
        .o_ready(rdy_o[1]), .o_valid(vld_o[1]), .o_data_bus(d1), .o_overflow(ovf_o[1]),
        .i_ready(rdy));
    psum_accumulator #(.IN_WIDTH(5), .ACC_WIDTH(8), .NUM_PSUM(1)) u2 (
        .clk(clk), .rst_n(rst_n), .i_en(en), .i_clear(clr), .i_valid(vld), .i_data_bus(din),
        .o_ready(rdy_o[2]), .o_valid(vld_o[2]), .o_data_bus(dout[2]), .o_overflow(ovf_o[2]),
        .i_ready(rdy));
    assign dout[1] = {2'b00, d1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a group is just the running total of its terms; the result
    // is that total modulo 2^ACC_WIDTH and it wrapped iff the total reached 2^ACC_WIDTH.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_cnt[k] = 0; m_sum[k] = 0; m_hold[k] = 0; m_res[k] = 0; m_ovf[k] = 0;
            end else if (clr) begin
                m_cnt[k] = 0; m_sum[k] = 0; m_hold[k] = 0;
            end else if (en) begin
                if (m_hold[k]) begin
                    if (rdy) m_hold[k] = 0;
                end else if (vld) begin
                    m_sum[k] += din;
                    m_cnt[k]++;
                    if (m_cnt[k] == np[k]) begin
                        m_hold[k] = 1;
                        m_res[k]  = int'(m_sum[k] % (64'd1 << aw[k]));
                        m_ovf[k]  = m_sum[k] >= (64'd1 << aw[k]);
                        m_cnt[k]  = 0;
                        m_sum[k]  = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("model_ready%0d", k), rdy_o[k], rst_n & en & !m_hold[k]);
                check($sformatf("model_valid%0d", k), vld_o[k], m_hold[k]);
                check($sformatf("model_data%0d", k), dout[k], m_res[k]);
                check($sformatf("model_ovf%0d", k), ovf_o[k], m_hold[k] & m_ovf[k]);
            end
        end
    end

    task automatic cyc(input bit v, input logic [4:0] d, input bit r);
        vld = v; din = d; rdy = r;
        @(posedge clk); #1;
    endtask

    task automatic group(input int a, input int b, input int c, input int e, input bit r);
        cyc(1, 5'(a), r); cyc(1, 5'(b), r); cyc(1, 5'(c), r); cyc(1, 5'(e), r);
    endtask

    initial begin
        @(posedge clk); #1;
        chk_on = 1'b1;
        @(posedge clk); #1;
        check("rst_valid", vld_o[0], 0);
        check("rst_data", dout[0], 0);
        check("rst_ovf", ovf_o[0], 0);
        check("rst_ready", rdy_o[0], 0);
        rst_n = 1'b1;

        group(3, 5, 7, 9, 1);
        check("b2b_valid", vld_o[0], 1);
        check("b2b_data", dout[0], 24);
        check("b2b_ovf", ovf_o[0], 0);
        check("b2b_ready", rdy_o[0], 0);
        cyc(0, 0, 1);
        check("b2b_pop", vld_o[0], 0);

        group(3, 5, 7, 9, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0);
            check("bp_valid", vld_o[0], 1);
            check("bp_data", dout[0], 24);
        end
        cyc(0, 0, 1);
        check("bp_pop", vld_o[0], 0);

        group(31, 31, 31, 31, 0);
        check("wrap_data", dout[1], 60);
        check("wrap_ovf", ovf_o[1], 1);
        check("wrap_wide", dout[0], 124);
        cyc(0, 0, 1);
        group(1, 1, 1, 1, 0);
        check("wrap2_data", dout[1], 4);
        check("wrap2_ovf", ovf_o[1], 0);
        cyc(0, 0, 1);

        cyc(1, 2, 0);
        cyc(0, 0, 0);
        en = 1'b0;
        cyc(1, 9, 0);
        en = 1'b1;
        cyc(1, 4, 0); cyc(1, 6, 0); cyc(1, 8, 0);
        check("gap_valid", vld_o[0], 1);
        check("gap_data", dout[0], 20);
        cyc(0, 0, 1);

        cyc(1, 10, 0); cyc(1, 10, 0);
        rst_n = 1'b0;
        cyc(0, 0, 0);
        rst_n = 1'b1;
        check("midrst_data", dout[0], 0);
        group(1, 2, 3, 4, 0);
        check("midrst_sum", dout[0], 10);
        cyc(0, 0, 1);

        cyc(1, 10, 0); cyc(1, 10, 0);
        clr = 1'b1;
        cyc(1, 7, 0);
        clr = 1'b0;
        check("clr_valid", vld_o[0], 0);
        group(1, 2, 3, 4, 0);
        check("clr_sum", dout[0], 10);
        cyc(0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            clr   = ($urandom_range(0, 39) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            cyc($urandom_range(0, 3) != 0, 5'($urandom), $urandom_range(0, 2) != 0);
        end

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
